// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access (data first).
// Optional access timeout with sticky error flag is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReqF,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        IReadyF,
  input  logic        DReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        DReadyM,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        MemStall,
  output logic        MemErr
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        d_done_q, d_done_d;
  logic        i_done_q, i_done_d;
  logic        err_q, err_d;
  logic        d_pend, i_pend;
  logic        timeout_hit;

  assign d_pend   = DReqM & ~d_done_q;
  assign i_pend   = IReqF & ~i_done_q;
  assign MemStall = d_pend | i_pend;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  // Abort on the cycle the count would reach TIMEOUT, so exactly TIMEOUT request cycles are seen.
  assign timeout_hit = mem_req_q & ~MemAck & (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE || state_d != state_q) begin
      cnt_q <= '0;
    end else if (mem_req_q && !MemAck) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    d_done_d    = d_done_q;
    i_done_d    = i_done_q;
    err_d       = err_q | timeout_hit;

    // Pipeline advances on this edge; a done flag set below takes precedence.
    if (!MemStall) begin
      d_done_d = 1'b0;
      i_done_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (d_pend) begin
          state_d     = DATA;
          mem_addr_d  = ALUOutM;
          mem_we_d    = MemWriteM;
          mem_wdata_d = WriteDataM;
        end else if (i_pend) begin
          state_d    = FETCH;
          mem_addr_d = PCF;
          mem_we_d   = 1'b0;
        end
      end
      DATA: begin
        if (MemAck || timeout_hit) begin
          if (!mem_we_q) rdata_d = timeout_hit ? 32'h0 : MemRData;
          d_done_d = 1'b1;
          if (i_pend) begin
            state_d    = FETCH;
            mem_addr_d = PCF;
            mem_we_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FETCH: begin
        if (MemAck || timeout_hit) begin
          instr_d  = timeout_hit ? 32'h0 : MemRData;
          i_done_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      instr_q     <= 32'h0;
      rdata_q     <= 32'h0;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
      d_done_q    <= d_done_d;
      i_done_q    <= i_done_d;
      err_q       <= err_d;
    end
  end

  assign MemReq    = mem_req_q;
  assign MemWE     = mem_we_q;
  assign MemAddr   = mem_addr_q;
  assign MemWData  = mem_wdata_q;
  assign InstrF    = instr_q;
  assign ReadDataM = rdata_q;
  assign DReadyM   = d_done_q;
  assign IReadyF   = i_done_q;
  assign MemErr    = err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the pipeline's instruction fetch (F stage) and data access (M stage). Each request is sequenced through a registered memory handshake, and data access always has priority. Returned data is held in registers, and a stall is raised to the hazard unit until every pending request in the current pipeline step has been serviced. Sits between the `arm` core and the external memory model, replacing its separate instruction and data ports.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles without `MemAck` before an access is aborted. Used only with `ARB_TIMEOUT_EN`; legal range 1..65535.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `IReqF`, input, 1: fetch request; held stable while `MemStall`=1.
- `PCF`, input, 32: fetch address.
- `InstrF`, output, 32: registered fetched instruction.
- `IReadyF`, output, 1: fetch for the current step is complete.
- `DReqM`, input, 1: data request (load or store); held stable while `MemStall`=1.
- `MemWriteM`, input, 1: 1 = store, 0 = load.
- `ALUOutM`, input, 32: data address.
- `WriteDataM`, input, 32: store data.
- `ReadDataM`, output, 32: registered load data.
- `DReadyM`, output, 1: data access for the current step is complete.
- `MemReq`, output, 1: memory request, registered.
- `MemWE`, output, 1: memory write enable, registered.
- `MemAddr`, output, 32: memory address, registered.
- `MemWData`, output, 32: memory write data, registered.
- `MemRData`, input, 32: memory read data; valid when `MemAck`=1.
- `MemAck`, input, 1: access complete; single-cycle pulse.
- `MemStall`, output, 1: combinational stall to the hazard unit; ORed into StallF/StallD and freezes E/M/W.
- `MemErr`, output, 1: sticky timeout flag.

## Operation
- State machine: IDLE, DATA, FETCH.
- Done flags `d_done` and `i_done` drive `DReadyM` and `IReadyF` directly.
- `MemStall` = (`DReqM` & ~`d_done`) | (`IReqF` & ~`i_done`).
- IDLE:
  - If `DReqM` & ~`d_done`: go to DATA and latch `ALUOutM`, `MemWriteM` and `WriteDataM` into `MemAddr`, `MemWE` and `MemWData`.
  - Else if `IReqF` & ~`i_done`: go to FETCH, latch `PCF` into `MemAddr`, set `MemWE`=0.
  - Else stay in IDLE.
- `MemReq` = 1 in DATA and FETCH, 0 in IDLE. Address, write enable and write data stay stable until `MemAck`.
- DATA with `MemAck`:
  - If the access is a load, `ReadDataM` <= `MemRData`; on a store, `ReadDataM` is unchanged.
  - Set `d_done`.
  - If a fetch is pending, go directly to FETCH with `PCF` latched; otherwise go to IDLE.
- FETCH with `MemAck`: `InstrF` <= `MemRData`, set `i_done`, go to IDLE.
- Step boundary: on any rising edge with `MemStall`=0, the pipeline advances and `d_done`/`i_done` clear to 0. A flag set on the same edge wins.
- `MemAck` in IDLE is ignored.
- A request changing while `MemStall`=1 is a protocol violation. It is not checked; the latched values are used.

## Timing
- Reset values: state IDLE; `MemReq`, `MemWE`, `IReadyF`, `DReadyM`, `MemErr` = 0; `MemAddr`, `MemWData`, `InstrF`, `ReadDataM` = 0.
- Reset is asynchronous at any point and aborts an in-flight access. `MemReq` drops immediately.
- Fetch only, with an ack in the first request cycle:
  - Cycle 0: `IReqF`=1, `MemStall`=1.
  - Cycle 1: `MemReq`=1, `MemAck`=1.
  - Cycle 2: `InstrF` valid, `IReadyF`=1, `MemStall`=0.
  - Cycle 3: flags cleared.
- Data + fetch in the same step, each acked in its first cycle:
  - Data `MemReq` in cycle 1, fetch `MemReq` in cycle 2.
  - `MemStall`=0 in cycle 3.
- Each extra wait cycle before `MemAck` adds one cycle.
- Throughput: at most one memory access per `MemAck`; no back-to-back gap between DATA and FETCH.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter of width $clog2(`TIMEOUT`+1) resets on entry to DATA/FETCH and increments each cycle with `MemReq`=1 & ~`MemAck`.
  - When it reaches `TIMEOUT`, the access is aborted: the destination register loads 32'h0000_0000, the done flag sets, `MemErr` <= 1 (sticky until reset), and the state advances as if acked.
- Undefined: no counter; the arbiter waits indefinitely; `MemErr` is tied to 0.

## Test plan
- Fetch only: `IReqF`=1, `PCF`=0x10, ack in cycle 1 with `MemRData`=0xE2800001 -> `InstrF`=0xE2800001 and `IReadyF`=1 in cycle 2; `MemStall` high in cycles 0-1 only.
- Load + fetch: `DReqM`=1, `MemWriteM`=0, `ALUOutM`=0x80, `PCF`=0x14 -> `MemAddr`=0x80 then 0x14 in consecutive cycles; `ReadDataM` = first ack data, `InstrF` = second; `MemStall` low in cycle 3.
- Store with 2 wait states: `ALUOutM`=0x40, `WriteDataM`=0xCAFE0001 -> `MemWE`=1 with `MemAddr`/`MemWData` stable for 3 cycles, `ReadDataM` unchanged, `DReadyM`=1 after the ack.
- Reset mid-access: assert `reset`=0 while in DATA -> `MemReq`=0 and outputs at reset values immediately. Release, then a stray `MemAck` -> ignored, state IDLE.
- Step boundary: two consecutive fetches to 0x00 and 0x04 with no idle request gap -> `i_done` clears on the advancing edge and the second fetch issues `MemReq` with `MemAddr`=0x04.
- `ARB_TIMEOUT_EN`, `TIMEOUT`=4, no ack on a fetch -> after 4 `MemReq` cycles: `InstrF`=0, `MemErr`=1 (sticky), `IReadyF`=1. Without the macro, `MemReq` stays high for 100 cycles and `MemErr`=0.
